// File: rtl/apb_tb_pkg.sv
`timescale 1ns/1ps
// Shared address map for the APB register harness.
package apb_tb_pkg;
    localparam int unsigned NUM_RW   = 5;
    localparam int unsigned NUM_RO   = 3;
    localparam int unsigned ADDR_RW0 = 0;
    localparam int unsigned ADDR_RW1 = 1;
    localparam int unsigned ADDR_RW2 = 2;
    localparam int unsigned ADDR_RW3 = 3;
    localparam int unsigned ADDR_RW4 = 4;
    localparam int unsigned ADDR_RO0 = 5;
    localparam int unsigned ADDR_RO1 = 6;
    localparam int unsigned ADDR_RO2 = 7;
endpackage

// File: rtl/apb_driver.sv
`timescale 1ns/1ps
// Behavioural APB3 master: task-driven reset and single transfers.
module apb_driver #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
) (
    input  logic              pclk,
    input  logic              pready,
    input  logic [DWIDTH-1:0] prdata,
    output logic              presetn,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AWIDTH-1:0] paddr,
    output logic [DWIDTH-1:0] pwdata
);
    task automatic initialization();
        psel    <= 1'b0;
        penable <= 1'b0;
        pwrite  <= 1'b0;
        paddr   <= '0;
        pwdata  <= '0;
        presetn <= 1'b1;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        presetn <= 1'b0;
        @(posedge pclk);
    endtask

    // Non-blocking drives let a following call re-assert psel in the
    // same timestep, so back-to-back transfers need no idle cycle.
    task automatic transfer(input logic wr,
                            input logic [AWIDTH-1:0] addr,
                            input logic [DWIDTH-1:0] data,
                            output logic [DWIDTH-1:0] rdata);
        psel    <= 1'b1;
        penable <= 1'b0;
        pwrite  <= wr;
        paddr   <= addr;
        if (wr)
            pwdata <= data;
        @(posedge pclk);
        penable <= 1'b1;
        do @(posedge pclk); while (!pready);
        rdata = prdata;
        psel    <= 1'b0;
        penable <= 1'b0;
    endtask

    task automatic write_data(input logic [AWIDTH-1:0] addr,
                              input logic [DWIDTH-1:0] data);
        logic [DWIDTH-1:0] dummy;
        transfer(1'b1, addr, data, dummy);
    endtask

    task automatic read_data(input logic [AWIDTH-1:0] addr,
                             output logic [DWIDTH-1:0] data_out);
        transfer(1'b0, addr, '0, data_out);
    endtask
endmodule

// File: rtl/apb_reg_slave.sv
`timescale 1ns/1ps
// APB3 zero-wait-state register file: 5 RW, 3 RO, rest unmapped.
module apb_reg_slave
    import apb_tb_pkg::*;
#(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [AWIDTH-1:0] paddr,
    input  logic [DWIDTH-1:0] pwdata,
    input  logic [DWIDTH-1:0] regr [NUM_RO],
    output logic [DWIDTH-1:0] regw [NUM_RW],
    output logic [DWIDTH-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);
    logic [31:0]       addr_i;
    logic              rw_hit;
    logic              ro_hit;
    logic              bad;
    logic [DWIDTH-1:0] rd_val;

    assign addr_i = 32'(paddr);

    always_comb begin
        rw_hit = 1'b0;
        ro_hit = 1'b0;
        case (addr_i)
            ADDR_RW0, ADDR_RW1, ADDR_RW2, ADDR_RW3, ADDR_RW4: rw_hit = 1'b1;
            ADDR_RO0, ADDR_RO1, ADDR_RO2:                     ro_hit = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_RW; i++)
            if (addr_i == 32'(i)) rd_val = regw[i];
        for (int i = 0; i < NUM_RO; i++)
            if (addr_i == 32'(ADDR_RO0 + i)) rd_val = regr[i];
    end

    assign bad     = pwrite ? !rw_hit : !(rw_hit || ro_hit);
    assign pslverr = psel && penable && bad && !presetn;
    assign pready  = 1'b1;

    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            for (int i = 0; i < NUM_RW; i++)
                regw[i] <= '0;
        end else if (psel && penable && pwrite && rw_hit) begin
            for (int i = 0; i < NUM_RW; i++)
                if (addr_i == 32'(i)) regw[i] <= pwdata;
        end
    end

    // Loaded on the setup edge so data is stable for the whole access phase.
    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn)
            prdata <= '0;
        else if (psel && !penable && !pwrite)
            prdata <= rd_val;
    end
endmodule

// File: rtl/apb_testbench.sv
`timescale 1ns/1ps
// Harness top: clock generation plus wiring of the master and slave.
module apb_testbench
    import apb_tb_pkg::*;
#(
    parameter int              AWIDTH     = 4,
    parameter int              DWIDTH     = 8,
    parameter int              CLK_PERIOD = 10,
    parameter logic [DWIDTH-1:0] RO_VAL_0 = 8'h11,
    parameter logic [DWIDTH-1:0] RO_VAL_1 = 8'h22,
    parameter logic [DWIDTH-1:0] RO_VAL_2 = 8'h33
) (
    output logic              pclk,
    output logic              presetn,
    output logic [DWIDTH-1:0] regr_in_0,
    output logic [DWIDTH-1:0] regr_in_1,
    output logic [DWIDTH-1:0] regr_in_2,
    output logic [DWIDTH-1:0] regw_out_0,
    output logic [DWIDTH-1:0] regw_out_1,
    output logic [DWIDTH-1:0] regw_out_2,
    output logic [DWIDTH-1:0] regw_out_3,
    output logic [DWIDTH-1:0] regw_out_4,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AWIDTH-1:0] paddr,
    output logic [DWIDTH-1:0] pwdata,
    output logic [DWIDTH-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);
    logic              clk = 1'b0;
    logic [DWIDTH-1:0] regw [NUM_RW];
    logic [DWIDTH-1:0] regr [NUM_RO];

    always #(CLK_PERIOD / 2) clk = ~clk;

    assign pclk       = clk;
    assign regr_in_0  = RO_VAL_0;
    assign regr_in_1  = RO_VAL_1;
    assign regr_in_2  = RO_VAL_2;
    assign regr[0]    = regr_in_0;
    assign regr[1]    = regr_in_1;
    assign regr[2]    = regr_in_2;
    assign regw_out_0 = regw[0];
    assign regw_out_1 = regw[1];
    assign regw_out_2 = regw[2];
    assign regw_out_3 = regw[3];
    assign regw_out_4 = regw[4];

    apb_driver #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) i_apb_driver (
        .pclk    (pclk),
        .pready  (pready),
        .prdata  (prdata),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata)
    );

    apb_reg_slave #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) i_apb_slave (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .regr    (regr),
        .regw    (regw),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );
endmodule

// File: tb/tb_apb_testbench.sv
`timescale 1ns/1ps
// Self-checking bench for the APB register harness.
module tb_apb_testbench;
    logic       pclk, presetn, psel, penable, pwrite, pready, pslverr;
    logic [7:0] regr_in_0, regr_in_1, regr_in_2;
    logic [7:0] regw_out_0, regw_out_1, regw_out_2, regw_out_3, regw_out_4;
    logic [3:0] paddr;
    logic [7:0] pwdata, prdata;

    int checks = 0;
    int errors = 0;
    int setup_tot = 0;
    int acc_tot = 0;
    int proto_bad = 0;
    logic acc_err = 1'b0;

    logic [7:0] model [5];
    int         ro_vals [3] = '{8'h11, 8'h22, 8'h33};

    apb_testbench dut (
        .pclk(pclk), .presetn(presetn),
        .regr_in_0(regr_in_0), .regr_in_1(regr_in_1), .regr_in_2(regr_in_2),
        .regw_out_0(regw_out_0), .regw_out_1(regw_out_1),
        .regw_out_2(regw_out_2), .regw_out_3(regw_out_3),
        .regw_out_4(regw_out_4),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // Mid-cycle bus monitor: phase counts and protocol sanity.
    always @(negedge pclk) begin
        if (psel && !penable) setup_tot <= setup_tot + 1;
        if (psel && penable) begin
            acc_tot <= acc_tot + 1;
            acc_err <= pslverr;
        end
        if ((penable && !psel) || !pready) proto_bad <= proto_bad + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_err(input logic wr, input int a);
        if (a < 5) return 1'b0;
        if (a < 8) return wr;
        return 1'b1;
    endfunction

    function automatic logic [7:0] exp_rd(input int a);
        if (a < 5) return model[a];
        if (a < 8) return 8'(ro_vals[a-5]);
        return 8'h00;
    endfunction

    function automatic logic [39:0] model_regs();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    task automatic chk_regs(input string tag);
        chk(tag, {regw_out_4, regw_out_3, regw_out_2, regw_out_1, regw_out_0},
            model_regs());
    endtask

    task automatic do_init();
        dut.i_apb_driver.initialization();
        foreach (model[i]) model[i] = 8'h00;
        #1;
    endtask

    task automatic do_write(input int a, input int d);
        int s0, a0;
        s0 = setup_tot;
        a0 = acc_tot;
        dut.i_apb_driver.write_data(4'(a), 8'(d));
        #1;
        chk("wr_setup", setup_tot - s0, 1);
        chk("wr_access", acc_tot - a0, 1);
        chk("wr_err", acc_err, exp_err(1'b1, a));
        if (!exp_err(1'b1, a)) model[a] = 8'(d);
        chk_regs("wr_regs");
    endtask

    task automatic do_read(input int a);
        int s0, a0;
        logic [7:0] d;
        s0 = setup_tot;
        a0 = acc_tot;
        dut.i_apb_driver.read_data(4'(a), d);
        #1;
        chk("rd_setup", setup_tot - s0, 1);
        chk("rd_access", acc_tot - a0, 1);
        chk("rd_err", acc_err, exp_err(1'b0, a));
        chk("rd_data", d, exp_rd(a));
        chk_regs("rd_regs");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1);
    end

    initial begin
        do_init();
        chk("rst_regs", {regw_out_4, regw_out_3, regw_out_2,
                         regw_out_1, regw_out_0}, 40'h0);
        chk("rst_prdata", prdata, 8'h00);
        chk("rst_pslverr", pslverr, 1'b0);
        chk("rst_pready", pready, 1'b1);

        do_write(1, 8'hAA);
        do_write(2, 8'h55);
        do_read(1);
        chk("wr_rd_reg1", regw_out_1, 8'hAA);
        chk("wr_rd_reg2", regw_out_2, 8'h55);

        for (int i = 0; i < 5; i++) do_write(i, 8'h10 + i);
        for (int i = 0; i < 5; i++) do_read(i);
        do_init();
        chk_regs("sweep_rst");

        for (int i = 5; i < 8; i++) do_read(i);
        do_write(6, 8'hFF);
        do_read(6);

        do_write(1, 8'h3C);
        do_write(12, 8'h99);
        do_read(15);

        do_write(3, 8'h5A);
        fork
            dut.i_apb_driver.write_data(4'd3, 8'h77);
            begin
                @(posedge penable);
                #2;
                dut.i_apb_driver.initialization();
            end
            begin
                @(posedge penable);
                #3;
                chk("midrst_now", regw_out_3, 8'h00);
            end
        join
        foreach (model[i]) model[i] = 8'h00;
        #1;
        chk("midrst_after", regw_out_3, 8'h00);
        chk_regs("midrst_regs");
        chk("midrst_prdata", prdata, 8'h00);

        for (int n = 0; n < 200; n++) begin
            int a;
            a = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                do_write(a, int'($urandom_range(0, 255)));
            else
                do_read(a);
        end

        chk("proto_bad", proto_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_testbench.md
Name: apb_testbench

Overview:
- Self-contained APB3 register subsystem harness: internal clock/reset generation, a behavioural APB master sub-module, and a synthesizable APB slave register file.
- Every APB bus signal and register output is exported as a top-level output for observation.
- Test cases drive it only through hierarchical calls to the driver instance i_apb_driver: initialization(), write_data(addr, data), read_data(addr, data_out).

Parameters:
- AWIDTH, 4, APB address width.
- DWIDTH, 8, APB data and register width.
- CLK_PERIOD, 10, pclk period in ns.
- RO_VAL_0 / RO_VAL_1 / RO_VAL_2, 8'h11 / 8'h22 / 8'h33, constants driven onto regr_in_0..2.

Ports:
- pclk  output  1  Free-running clock, generated internally, 50% duty.
- presetn  output  1  Reset. Asynchronous, active-high; the name is kept per codebase convention.
- regr_in_0..regr_in_2  output  DWIDTH  Read-only register sources, equal to RO_VAL_0..2.
- regw_out_0..regw_out_4  output  DWIDTH  Contents of writable registers 0..4.
- psel  output  1  APB select (master).
- penable  output  1  APB enable (master).
- pwrite  output  1  APB direction, 1 = write (master).
- paddr  output  AWIDTH  APB address (master).
- pwdata  output  DWIDTH  APB write data (master).
- prdata  output  DWIDTH  APB read data (slave).
- pready  output  1  APB ready (slave).
- pslverr  output  1  APB error (slave).

Behaviour:
- Clock: pclk starts at 0 and toggles every CLK_PERIOD/2.
- initialization():
  - Drives psel, penable, pwrite, paddr and pwdata to 0.
  - Asserts presetn = 1 for 2 pclk cycles, then deasserts it on a falling edge.
  - Returns on the next rising edge.
- Reset, applied asynchronously and also mid-transfer:
  - regw_out_0..4 = 0, prdata = 0, pslverr = 0.
  - pready stays 1.
- Register map, slave side:
  - Address 0..4: RW registers regw_out_0..4.
  - Address 5..7: RO, returning regr_in_0..2.
  - Address 8..15: unmapped.
- Transfer protocol: APB3 with zero wait states; pready = 1 always.
  - Setup phase: psel = 1, penable = 0.
  - Access phase: psel = 1, penable = 1. The transfer completes at the rising edge of pclk in the access phase.
- Write:
  - At completion, the target RW register loads pwdata.
  - regw_out reflects the new value after that edge.
- Read: prdata is registered.
  - It is loaded at the setup-phase rising edge with the addressed value, so it is valid throughout the access phase.
  - Otherwise it holds its last value.
- Errors:
  - pslverr = 1 during the access phase for a write to an RO address, or any access to an unmapped address. It is 0 otherwise.
  - An errored write modifies nothing.
  - An errored read returns prdata = 0.
- Driver tasks:
  - Each transfer is 2 cycles: setup, then access.
  - After completion the driver deasserts psel and penable; paddr and pwdata hold.
  - read_data samples prdata at the completing edge and returns it.
  - Back-to-back calls are legal and produce no idle cycle requirement.
- Simultaneous events:
  - Reset has priority over any write on the same edge.
  - A write followed immediately by a read of the same address returns the new value.
- Width rules: addresses compare over the full AWIDTH bits; data has no width extension.

Decomposition:
- Package apb_tb_pkg holds:
  - Address localparams: ADDR_RW0..ADDR_RW4 = 0..4, ADDR_RO0..ADDR_RO2 = 5..7.
  - NUM_RW = 5, NUM_RO = 3.
- Sub-modules:
  - apb_driver, behavioural master with tasks; instance name i_apb_driver, fixed.
  - apb_reg_slave, synthesizable, instance i_apb_slave.
- The top module only wires these and generates the clock.

Test Plan:
- Write then read: initialization(); write 1 = 8'hAA; write 2 = 8'h55; read 1 -> 8'hAA, regw_out_1 = 8'hAA, regw_out_2 = 8'h55, pslverr = 0.
- Full RW sweep: write addresses 0..4 with 8'h10..8'h14; read each back -> identical values; after reset all regw_out = 0.
- RO registers:
  - Read 5, 6, 7 -> 8'h11, 8'h22, 8'h33.
  - Write 8'hFF to 6 -> pslverr = 1 in the access phase; re-read gives 8'h22.
- Unmapped address: write to 4'hC -> pslverr = 1 and no regw_out changes; read 4'hF -> pslverr = 1, prdata = 0.
- Mid-transfer reset: assert presetn during the access phase of a write of 8'h77 to 3 -> regw_out_3 = 0 immediately and stays 0.
- Protocol timing:
  - Each transfer shows exactly one setup cycle and one access cycle.
  - penable is never 1 without psel.
  - pready = 1 throughout.
